muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle integer multiply/divide unit producing HI/LO
// register writes.
//
// Operations (op): 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
//   Multiply: one MUL cycle, then one DONE cycle.
//   Divide:   32 DIV cycles (restoring, one quotient bit each), then DONE.
//
// Ports:
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous, active-high reset
//   start    in   1   begin an operation (sampled only in IDLE)
//   op       in   2   operation code
//   src1     in  32   multiplicand / dividend
//   src2     in  32   multiplier / divisor
//   cancel   in   1   abort an in-flight operation (ignored in DONE)
//   busy     out  1   operation in flight (MUL or DIV)
//   done     out  1   one-cycle result-valid pulse
//   wen      out  2   {hi, lo} write enables
//   hiwdata  out 32   product[63:32] or remainder
//   lowdata  out 32   product[31:0] or quotient
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [1:0]  wen,
  output logic [31:0] hiwdata,
  output logic [31:0] lowdata
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic        op_signed;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [4:0]  count;
  logic [63:0] result;

  // The result register is the only source for the write data, so the
  // outputs naturally hold their last value between operations.
  assign hiwdata = result[63:32];
  assign lowdata = result[31:0];

  // Dividend magnitude is taken straight from the inputs at the accepting
  // edge; it seeds the quotient shift register.
  logic [31:0] dividend_mag;
  always_comb begin
    dividend_mag = src1;
    if (!op[0] && src1[31]) dividend_mag = 32'd0 - src1;
  end

  // Multiply: extend each operand to 64 bits (sign- or zero-extended by op)
  // so a single modulo-2^64 multiply yields both signed and unsigned products.
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  always_comb begin
    ext_a   = {{32{op_signed & src1_q[31]}}, src1_q};
    ext_b   = {{32{op_signed & src2_q[31]}}, src2_q};
    product = ext_a * ext_b;
  end

  // One restoring-divide step. The partial remainder is shifted left with
  // the next dividend bit; a 34-bit difference keeps the borrow visible even
  // when the shifted value itself needs 33 bits.
  logic [31:0] divisor_mag;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  always_comb begin
    divisor_mag = src2_q;
    if (op_signed && src2_q[31]) divisor_mag = 32'd0 - src2_q;
    shifted = {rem_q, quo_q[31]};
    diff    = {1'b0, shifted} - {2'b00, divisor_mag};
    if (diff[33]) begin
      rem_next = shifted[31:0];
      quo_next = {quo_q[30:0], 1'b0};
    end else begin
      rem_next = diff[31:0];
      quo_next = {quo_q[30:0], 1'b1};
    end
  end

  // Final divide result after the last step. A zero divisor bypasses the sign
  // fix-up so that hi mirrors the raw dividend and lo is all ones for both
  // DIV and DIVU. The most-negative / -1 case needs no special handling:
  // negating 0x80000000 wraps back to itself.
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  always_comb begin
    div_lo = quo_next;
    div_hi = rem_next;
    if (op_signed && (src1_q[31] ^ src2_q[31])) div_lo = 32'd0 - quo_next;
    if (op_signed && src1_q[31])                div_hi = 32'd0 - rem_next;
    if (src2_q == 32'd0) begin
      div_lo = 32'hFFFF_FFFF;
      div_hi = src1_q;
    end
  end

  // Control FSM with registered busy/done/wen. done and wen are raised on the
  // edge that enters DONE and dropped on the edge that leaves it, so they are
  // high for exactly the DONE cycle. cancel is honoured only in MUL and DIV.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_signed <= 1'b0;
      src1_q    <= 32'd0;
      src2_q    <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      count     <= 5'd0;
      result    <= 64'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wen       <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          wen  <= 2'b00;
          if (start && !cancel) begin
            op_signed <= ~op[0];
            src1_q    <= src1;
            src2_q    <= src2;
            rem_q     <= 32'd0;
            quo_q     <= dividend_mag;
            count     <= 5'd0;
            busy      <= 1'b1;
            state     <= op[1] ? DIV : MUL;
          end
        end
        MUL: begin
          busy <= 1'b0;
          if (cancel) begin
            state <= IDLE;
          end else begin
            result <= product;
            done   <= 1'b1;
            wen    <= 2'b11;
            state  <= DONE;
          end
        end
        DIV: begin
          if (cancel) begin
            busy  <= 1'b0;
            count <= 5'd0;
            state <= IDLE;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            count <= count + 5'd1;
            if (count == 5'd31) begin
              result <= {div_hi, div_lo};
              busy   <= 1'b0;
              done   <= 1'b1;
              wen    <= 2'b11;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          wen   <= 2'b00;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          wen   <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// A transaction-level model (arithmetic result plus a latency countdown)
// predicts busy/done/wen/hiwdata/lowdata for every cycle; directed vectors
// additionally carry hand-computed literal results and latencies.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [1:0]  wen;
  logic [31:0] hiwdata;
  logic [31:0] lowdata;

  int errors = 0;
  int checks = 0;

  muldiv_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src1    (src1),
    .src2    (src2),
    .cancel  (cancel),
    .busy    (busy),
    .done    (done),
    .wen     (wen),
    .hiwdata (hiwdata),
    .lowdata (lowdata)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Architectural result of an operation, {hi, lo}, from plain arithmetic.
  function automatic logic [63:0] reference(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    logic [63:0]     res;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    res = 64'd0;
    case (o)
      2'b00: begin sp = sa * sb; res = sp; end
      2'b01: begin up = ua * ub; res = up; end
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Transaction model: an accepted op becomes in flight for its latency
  // (1 cycle multiply, 32 cycles divide), then produces one write cycle.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [63:0] m_pend = 64'd0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      if (cancel) m_busy = 1'b0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_hi   = m_pend[63:32];
          m_lo   = m_pend[31:0];
        end
      end
    end else if (start && !cancel) begin
      m_pend = reference(op, src1, src2);
      m_busy = 1'b1;
      m_left = op[1] ? 32 : 1;
    end
  end

  // Compare every output against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
    checkOutput("cyc_done", {31'd0, done}, {31'd0, m_done});
    checkOutput("cyc_wen", {30'd0, wen}, m_done ? 32'd3 : 32'd0);
    checkOutput("cyc_hi", hiwdata, m_hi);
    checkOutput("cyc_lo", lowdata, m_lo);
  end

  // Issue one start for one cycle, then scramble the operand inputs.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src1  = a;
    src2  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    src1  = $urandom;
    src2  = $urandom;
  endtask

  // Count falling edges until done (bounded); also count busy cycles seen.
  task automatic waitDone(input int max, output int lat, output int bcyc);
    lat  = max + 1;
    bcyc = 0;
    for (int n = 1; n <= max; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (busy === 1'b1) bcyc++;
    end
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int bcyc;
    int seen;

    vecs[0]  = '{"multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2};
    vecs[1]  = '{"mult_neg",    2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2};
    vecs[2]  = '{"div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3]  = '{"divu_by0",    2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{"div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
    vecs[5]  = '{"div_7_m2",    2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
    vecs[6]  = '{"div_m7_m2",   2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 33};
    vecs[7]  = '{"div_by0",     2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33};
    vecs[8]  = '{"mult_minsq",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2};
    vecs[9]  = '{"divu_max_10", 2'b11, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 33};
    vecs[10] = '{"multu_wide",  2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 2};

    start  = 1'b0;
    cancel = 1'b0;
    op     = 2'b00;
    src1   = 32'd0;
    src2   = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_wen", {30'd0, wen}, 32'd0);
    checkOutput("reset_hi", hiwdata, 32'd0);
    checkOutput("reset_lo", lowdata, 32'd0);
    reset = 1'b0;
    $display("[TB] reset released, running directed vectors");

    // Back-to-back directed vectors; the first start lands on the first edge
    // after reset release.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone(40, lat, bcyc);
      checkOutput({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      checkOutput({vecs[i].name, "_busycyc"}, bcyc, vecs[i].lat - 1);
      checkOutput({vecs[i].name, "_wen"}, {30'd0, wen}, 32'd3);
      checkOutput({vecs[i].name, "_hi"}, hiwdata, vecs[i].hi);
      checkOutput({vecs[i].name, "_lo"}, lowdata, vecs[i].lo);
      @(posedge clk);
      #1;
    end

    // Cancel a divide in its tenth cycle, then multiply immediately after.
    applyStimulus(2'b10, 32'd50, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    checkOutput("cancel_busy", {31'd0, busy}, 32'd0);
    checkOutput("cancel_wen", {30'd0, wen}, 32'd0);
    applyStimulus(2'b01, 32'd3, 32'd4);
    waitDone(40, lat, bcyc);
    checkOutput("after_cancel_lat", lat, 2);
    checkOutput("after_cancel_lo", lowdata, 32'd12);
    checkOutput("after_cancel_hi", hiwdata, 32'd0);
    @(posedge clk);
    #1;

    // start pulsed while a divide is busy must be ignored.
    applyStimulus(2'b11, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    op    = 2'b01;
    src1  = 32'd5;
    src2  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(40, lat, bcyc);
    checkOutput("busy_start_lat", lat, 28);
    checkOutput("busy_start_lo", lowdata, 32'd14);
    checkOutput("busy_start_hi", hiwdata, 32'd2);
    @(posedge clk);
    #1;

    // Cancel coincident with DONE: the write still happens.
    applyStimulus(2'b00, 32'hFFFF_FFFE, 32'd3);
    @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    checkOutput("cancel_done_done", {31'd0, done}, 32'd1);
    checkOutput("cancel_done_wen", {30'd0, wen}, 32'd3);
    checkOutput("cancel_done_lo", lowdata, 32'hFFFF_FFFA);
    @(posedge clk);
    #1;
    cancel = 1'b0;

    // start together with cancel in IDLE is ignored.
    start  = 1'b1;
    cancel = 1'b1;
    op     = 2'b01;
    src1   = 32'd9;
    src2   = 32'd9;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    checkOutput("idle_cancel_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a divide.
    applyStimulus(2'b10, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_done", {31'd0, done}, 32'd0);
    checkOutput("async_hi", hiwdata, 32'd0);
    checkOutput("async_lo", lowdata, 32'hFFFF_FFFA & 32'd0);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || wen !== 2'b00) seen++;
    end
    checkOutput("async_no_done", seen, 0);
    @(posedge clk);
    #1;

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
